// File: rtl/stream_blk_mgr.sv
// Byte-stream packer and digest serializer for the block hash core.
// Full blocks are parked until finality is known; the digest drains low byte first.
module stream_blk_mgr #(
  parameter int              W         = 32,
  parameter logic [8*W-1:0]  TEST_MASK = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                finish,
  input  logic                tst,
  input  logic [$clog2(W):0]  outlen,
  input  logic [7:0]          din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [16*W-1:0]     blk_m,
  output logic [2*W-1:0]      blk_t,
  output logic                blk_f,
  output logic                blk_valid,
  input  logic                blk_ready,
  input  logic [8*W-1:0]      h_in,
  input  logic                h_valid,
  output logic [7:0]          dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                busy
);
  localparam int B  = 2 * W;
  localparam int MB = 16 * W;
  localparam int CW = $clog2(B) + 1;
  localparam int OW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(B - 1);
  localparam logic [OW-1:0] LEN_MAX  = OW'(W);

  typedef enum logic [2:0] {IDLE, FILL, HOLD, SEND, WAIT_H, DRAIN} state_t;
  state_t state, nxt;

  logic [MB-1:0]  m, ins;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] t;
  logic           f, tst_q;
  logic [OW-1:0]  len_q, out_cnt, len_norm;
  logic [8*W-1:0] h;

  // Byte k lands k bytes below the top of the block.
  assign ins      = {din, {(MB-8){1'b0}}} >> {cnt, 3'b000};
  assign len_norm = (outlen == '0 || outlen > LEN_MAX) ? LEN_MAX : outlen;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      FILL:    if (din_valid && cnt == CNT_LAST) nxt = HOLD;
               else if (!din_valid && finish)   nxt = SEND;
      HOLD:    if (din_valid || finish) nxt = SEND;
      SEND:    if (blk_ready) nxt = f ? WAIT_H : FILL;
      WAIT_H:  if (h_valid) nxt = DRAIN;
      DRAIN:   if (dout_ready && out_cnt == OW'(1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (start) nxt = FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0; cnt <= '0; t <= '0; f <= 1'b0; tst_q <= 1'b0;
      len_q <= '0; out_cnt <= '0; h <= '0;
    end else if (start) begin
      m <= '0; cnt <= '0; t <= '0; f <= 1'b0;
      tst_q <= tst; len_q <= len_norm;
    end else begin
      case (state)
        FILL: begin
          if (din_valid) begin
            m   <= m | ins;
            cnt <= cnt + 1'b1;
            t   <= t + 1'b1;
          end else if (finish) begin
            f <= 1'b1;
          end
        end
        // A waiting byte proves more data follows, so it wins over finish.
        HOLD:   if (!din_valid && finish) f <= 1'b1;
        SEND:   if (blk_ready && !f) begin m <= '0; cnt <= '0; end
        WAIT_H: if (h_valid) begin
                  h       <= h_in ^ (tst_q ? TEST_MASK : '0);
                  out_cnt <= len_q;
                end
        DRAIN:  if (dout_ready) begin
                  h       <= h >> 8;
                  out_cnt <= out_cnt - 1'b1;
                end
        default: ;
      endcase
    end
  end

  assign din_ready  = (state == FILL);
  assign blk_valid  = (state == SEND);
  assign blk_m      = m;
  assign blk_t      = {t[W-1:0], t[2*W-1:W]};
  assign blk_f      = f;
  assign dout       = h[7:0];
  assign dout_valid = (state == DRAIN);
  assign dout_last  = (state == DRAIN) && (out_cnt == OW'(1));
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_stream_blk_mgr.sv
// Scoreboard bench for stream_blk_mgr: a message-level model predicts blocks and digest
// bytes; a monitor compares whatever the DUT offers against the queued expectations.
module tb_stream_blk_mgr;
  localparam int W = 32;
  localparam logic [255:0] MASK =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4_FFFFFFFF;

  logic         clk = 1'b0;
  logic         rst, start, finish, tst;
  logic [5:0]   outlen;
  logic [7:0]   din;
  logic         din_valid, din_ready;
  logic [511:0] blk_m;
  logic [63:0]  blk_t;
  logic         blk_f, blk_valid, blk_ready;
  logic [255:0] h_in;
  logic         h_valid;
  logic [7:0]   dout;
  logic         dout_valid, dout_ready, dout_last, busy;

  stream_blk_mgr #(.W(W), .TEST_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .tst(tst), .outlen(outlen),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .blk_m(blk_m), .blk_t(blk_t), .blk_f(blk_f), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .h_in(h_in), .h_valid(h_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [511:0] m; logic [63:0] t; logic f; } exp_blk_s;
  typedef struct { logic [7:0] b; logic last; } exp_byte_s;
  typedef logic [7:0] msg_t [$];

  exp_blk_s  bq[$];
  exp_byte_s dq[$];
  int n_cmp = 0, n_err = 0, final_cnt = 0;
  int dr_mode = 0;
  bit dr_manual = 1'b0, stall = 1'b0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic die(input string nm);
    n_cmp++; n_err++;
    $display("FAIL %s: no response within cycle budget", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Model: message split into 64-byte chunks, zero padded, first byte at the top.
  task automatic push_blocks(input msg_t msg);
    int n = msg.size();
    int nb = (n == 0) ? 1 : (n + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      exp_blk_s e;
      e.m = '0;
      for (int k = 0; k < 64; k++)
        if (64*i + k < n) e.m[511-8*k -: 8] = msg[64*i + k];
      e.t = 64'((64*(i+1) < n) ? 64*(i+1) : n);
      e.f = (i == nb - 1);
      bq.push_back(e);
    end
  endtask

  task automatic push_digest(input logic [255:0] hv, input bit tst_i, input logic [5:0] ol);
    logic [255:0] hx = hv ^ (tst_i ? MASK : 256'd0);
    int len = (ol == 0 || ol > 32) ? 32 : int'(ol);
    for (int i = 0; i < len; i++) begin
      exp_byte_s e;
      e.b = hx[8*i +: 8];
      e.last = (i == len - 1);
      dq.push_back(e);
    end
  endtask

  // Monitor: compares every offered block/byte with the queue head, pops on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (blk_valid) begin
        if (bq.size() == 0) chk("blk_unexpected", 512'(blk_valid), 512'(0));
        else begin
          chk("blk_m", blk_m, bq[0].m);
          chk("blk_t", 512'(blk_t), 512'({bq[0].t[31:0], bq[0].t[63:32]}));
          chk("blk_f", 512'(blk_f), 512'(bq[0].f));
          chk("din_ready_in_send", 512'(din_ready), 512'(0));
          if (blk_ready) begin
            if (bq[0].f) final_cnt++;
            void'(bq.pop_front());
          end
        end
      end
      if (dout_valid) begin
        if (dq.size() == 0) chk("dout_unexpected", 512'(dout_valid), 512'(0));
        else begin
          chk("dout", 512'(dout), 512'(dq[0].b));
          chk("dout_last", 512'(dout_last), 512'(dq[0].last));
          if (dout_ready) void'(dq.pop_front());
        end
      end
    end
  end

  // Backpressure drivers, applied slightly after the edge so main-thread settings land first.
  initial begin
    int sc = 0;
    blk_ready = 1'b0; dout_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      sc = blk_valid ? sc + 1 : 0;
      blk_ready = stall ? (sc > 5) : ($urandom_range(0, 3) != 0);
      case (dr_mode)
        0:       dout_ready = ($urandom_range(0, 2) != 0);
        1:       dout_ready = ~dout_ready;
        default: dout_ready = dr_manual;
      endcase
    end
  end

  task automatic begin_msg(input bit tst_i, input logic [5:0] ol);
    start = 1'b1; finish = 1'b0; tst = tst_i; outlen = ol;
    @(posedge clk); #1;
    start = 1'b0; tst = 1'($urandom); outlen = 6'($urandom);
  endtask

  task automatic feed(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    din = b; din_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (din_ready) begin ok = 1'b1; break; end
    end
    if (!ok) die("din_ready_timeout");
    @(posedge clk); #1;
    din_valid = 1'b0; din = 8'($urandom);
    if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic feed_and_finish(input msg_t msg, input bit gaps);
    int fc0 = final_cnt;
    bit ok = 1'b0;
    foreach (msg[k]) feed(msg[k], gaps);
    finish = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("finish_to_blk_valid", 512'(blk_valid), 512'(1));
    for (int i = 0; i < 3000; i++) begin
      if (final_cnt != fc0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) die("final_block_timeout");
    @(posedge clk); #1;
  endtask

  task automatic run_body(input msg_t msg, input bit tst_i, input logic [5:0] ol,
                          input logic [255:0] hv, input bit gaps);
    bit ok = 1'b0;
    feed_and_finish(msg, gaps);
    push_digest(hv, tst_i, ol);
    h_in = hv; h_valid = 1'b1;
    @(posedge clk); #1;
    h_valid = 1'b0; h_in = rnd256();
    @(negedge clk);
    chk("h_to_dout_valid", 512'(dout_valid), 512'(1));
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) die("drain_timeout");
    chk("idle_din_ready", 512'(din_ready), 512'(0));
    chk("idle_dout_valid", 512'(dout_valid), 512'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_msg(input msg_t msg, input bit tst_i, input logic [5:0] ol,
                         input logic [255:0] hv, input bit gaps);
    push_blocks(msg);
    begin_msg(tst_i, ol);
    run_body(msg, tst_i, ol, hv, gaps);
  endtask

  initial begin
    #900000;
    die("watchdog");
  end

  initial begin
    msg_t msg;
    logic [255:0] hv;
    rst = 1'b1; start = 1'b0; finish = 1'b0; tst = 1'b0; outlen = '0;
    din = '0; din_valid = 1'b0; h_in = '0; h_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_din_ready", 512'(din_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_f", 512'(blk_f), 512'(0));
    chk("rst_blk_m", blk_m, 512'(0));
    chk("rst_blk_t", 512'(blk_t), 512'(0));
    chk("rst_dout_valid", 512'(dout_valid), 512'(0));
    chk("rst_dout_last", 512'(dout_last), 512'(0));
    chk("rst_dout", 512'(dout), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Empty message, 4-byte digest with toggling consumer.
    dr_mode = 1;
    msg = {};
    hv = rnd256(); hv[31:0] = 32'h44332211;
    run_msg(msg, 1'b0, 6'd4, hv, 1'b0);

    // "abc", outlen 0 means full width.
    dr_mode = 0;
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b0, 6'd0, rnd256(), 1'b0);

    // Exactly one full block: final flag must ride on it.
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'(i));
    run_msg(msg, 1'b0, 6'd40, rnd256(), 1'b0);

    // 65 bytes with blk_ready held low five cycles per offer.
    stall = 1'b1;
    msg = {};
    for (int i = 0; i < 65; i++) msg.push_back(8'($urandom));
    run_msg(msg, 1'b0, 6'd8, rnd256(), 1'b0);
    stall = 1'b0;

    // Test mode XOR mask.
    dr_mode = 1;
    msg = {};
    for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
    hv = rnd256(); hv[31:0] = 32'h44332211;
    run_msg(msg, 1'b1, 6'd4, hv, 1'b1);

    // Abort mid-drain after two bytes, then a stray h_valid in FILL.
    dr_mode = 2; dr_manual = 1'b0;
    msg = {8'h01, 8'h02, 8'h03};
    push_blocks(msg);
    begin_msg(1'b0, 6'd4);
    feed_and_finish(msg, 1'b0);
    hv = rnd256();
    push_digest(hv, 1'b0, 6'd4);
    h_in = hv; h_valid = 1'b1; dr_manual = 1'b1;
    @(posedge clk); #1;
    h_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    dr_manual = 1'b0;
    begin_msg(1'b0, 6'd2);
    dq.delete();
    @(negedge clk);
    chk("abort_dout_valid", 512'(dout_valid), 512'(0));
    chk("abort_din_ready", 512'(din_ready), 512'(1));
    msg = {8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h99};
    push_blocks(msg);
    @(posedge clk); #1;
    h_in = rnd256(); h_valid = 1'b1;
    @(posedge clk); #1;
    h_valid = 1'b0;
    @(negedge clk);
    chk("stray_h_dout_valid", 512'(dout_valid), 512'(0));
    @(posedge clk); #1;
    dr_mode = 0;
    run_body(msg, 1'b0, 6'd2, rnd256(), 1'b1);

    // Randomized messages.
    for (int r = 0; r < 10; r++) begin
      int n = $urandom_range(0, 150);
      msg = {};
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      run_msg(msg, 1'($urandom), 6'($urandom_range(0, 40)), rnd256(), 1'b1);
    end

    chk("blk_queue_drained", 512'(bq.size()), 512'(0));
    chk("dout_queue_drained", 512'(dq.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
